compare_stream_arbiter: RTL and testbench

Shares one file-compare checker between several DUT output streams in the testbench. Per cycle, a round-robin arbiter picks one valid source, registers its beat and forwards it to the single checker port. The block watches the checker's done/error flags and a stall watchdog, then latches a sticky PASS, FAIL or TIMEOUT verdict that the bench's end-of-test logic reads.

---
 rtl/compare_stream_arbiter.sv | 131 +++++++++++++
 tb/tb_compare_stream_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_stream_arbiter.sv
// Round-robin funnel from several stream sources into one file-compare checker port.
// A watchdog and the checker's done/error flags resolve a sticky PASS/FAIL/TIMEOUT verdict.
module compare_stream_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          cmp_valid,
    output logic [DATA_WIDTH-1:0]         cmp_data,
    output logic [SRC_W-1:0]              cmp_src,
    input  logic                          cmp_done,
    input  logic                          cmp_error,
    output logic [31:0]                   beat_count,
    output logic                          busy,
    output logic                          pass,
    output logic                          fail,
    output logic                          timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPass,
        StFail,
        StTimeout
    } state_e;

    state_e                 state_q;
    logic [SRC_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       idle_q;

    logic [2*NUM_SRC-1:0]   valid_dbl;
    logic [NUM_SRC-1:0]     valid_rot;
    logic                   grant_any;
    int                     grant_off;
    int                     grant_sum;
    logic [SRC_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic                   accept;
    logic [SRC_W-1:0]       ptr_next;
    logic [CNT_W-1:0]       idle_inc;

    // Grant search: rotate valids so ptr sits at bit 0, lowest set bit wins.
    always_comb begin
        valid_dbl = {src_valid, src_valid};
        valid_rot = valid_dbl[ptr_q +: NUM_SRC];
        grant_any = |valid_rot;
        grant_off = 0;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            if (valid_rot[k]) grant_off = k;
        end
        grant_sum = int'(ptr_q) + grant_off;
        if (grant_sum >= int'(NUM_SRC)) grant_sum = grant_sum - int'(NUM_SRC);
        grant_idx = SRC_W'(grant_sum);
    end

    // One-hot ready, only while running, plus the data mux for the granted source.
    always_comb begin
        accept     = (state_q == StRun) && grant_any;
        src_ready  = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                src_ready[i] = accept;
                grant_data   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_next = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        idle_inc = (idle_q == CNT_W'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
    end

    // State machine, pointer, watchdog, forwarded beat register and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            idle_q     <= '0;
            cmp_valid  <= 1'b0;
            cmp_data   <= '0;
            cmp_src    <= '0;
            beat_count <= '0;
        end else begin
            cmp_valid <= 1'b0;
            if (accept) begin
                cmp_valid <= 1'b1;
                cmp_data  <= grant_data;
                cmp_src   <= grant_idx;
                ptr_q     <= ptr_next;
                if (beat_count != 32'hFFFF_FFFF) beat_count <= beat_count + 32'd1;
            end

            case (state_q)
                StIdle: begin
                    idle_q <= '0;
                    if (|src_valid) state_q <= StRun;
                end
                StRun: begin
                    idle_q <= accept ? '0 : idle_inc;
                    // Error outranks done; the watchdog only fires on a silent cycle.
                    if (cmp_error) begin
                        state_q <= StFail;
                    end else if (cmp_done) begin
                        state_q <= StPass;
                    end else if (!accept && idle_inc == CNT_W'(TIMEOUT)) begin
                        state_q <= StTimeout;
                    end
                end
                default: begin
                    idle_q <= '0;
                end
            endcase
        end
    end

    // Status flags decoded straight from the registered state.
    always_comb begin
        busy    = (state_q == StRun);
        pass    = (state_q == StPass);
        fail    = (state_q == StFail);
        timeout = (state_q == StTimeout);
    end

endmodule

// File: tb/tb_compare_stream_arbiter.sv
// Directed plus randomized bench for compare_stream_arbiter (4 sources, watchdog 16).
module tb_compare_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int T  = 16;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;
    localparam int M_TO   = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic            cmp_valid;
    logic [DW-1:0]   cmp_data;
    logic [1:0]      cmp_src;
    logic            cmp_done;
    logic            cmp_error;
    logic [31:0]     beat_count;
    logic            busy, pass, fail, timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: verdict, rotating pointer, silent-cycle count, forwarded beat.
    int          m_state;
    int          m_ptr;
    int          m_idle;
    logic [31:0] m_beats;
    logic        m_cv;
    logic [31:0] m_data;
    int          m_src;
    int          m_last_grant;

    compare_stream_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (N),
        .TIMEOUT    (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .cmp_valid  (cmp_valid),
        .cmp_data   (cmp_data),
        .cmp_src    (cmp_src),
        .cmp_done   (cmp_done),
        .cmp_error  (cmp_error),
        .beat_count (beat_count),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state      = M_IDLE;
        m_ptr        = 0;
        m_idle       = 0;
        m_beats      = 32'd0;
        m_cv         = 1'b0;
        m_data       = 32'd0;
        m_src        = 0;
        m_last_grant = -1;
    endtask

    // Check every output mid-cycle, then advance the model over the coming edge.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        g = (m_state == M_RUN) ? model_grant(src_valid, m_ptr) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("src_ready", src_ready, exp_ready);
        chk("cmp_valid", cmp_valid, m_cv);
        chk("cmp_data", cmp_data, m_data);
        chk("cmp_src", cmp_src, m_src);
        chk("beat_count", beat_count, m_beats);
        chk("busy", busy, m_state == M_RUN);
        chk("pass", pass, m_state == M_PASS);
        chk("fail", fail, m_state == M_FAIL);
        chk("timeout", timeout, m_state == M_TO);
        m_last_grant = g;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_cv = 1'b0;
            if (g >= 0) begin
                m_cv   = 1'b1;
                m_data = src_data[g*DW +: DW];
                m_src  = g;
                m_ptr  = (g + 1) % N;
                if (m_beats != 32'hFFFF_FFFF) m_beats = m_beats + 1;
            end
            if (m_state == M_IDLE) begin
                m_idle = 0;
                if (src_valid != '0) m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                m_idle = (g >= 0) ? 0 : ((m_idle + 1 > T) ? T : m_idle + 1);
                if (cmp_error) m_state = M_FAIL;
                else if (cmp_done) m_state = M_PASS;
                else if (m_idle == T) m_state = M_TO;
            end else begin
                m_idle = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    // Random traffic; a valid, ungranted source keeps its beat unchanged.
    task automatic rand_run(input int n, input int done_pm, input int err_pm, input int rst_pm);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] || m_last_grant == i) begin
                    src_valid[i]         = ($urandom_range(0, 99) < 70);
                    src_data[i*DW +: DW] = $urandom;
                end
            end
            cmp_done  = ($urandom_range(0, 999) < done_pm);
            cmp_error = ($urandom_range(0, 999) < err_pm);
            rst_n     = !($urandom_range(0, 999) < rst_pm);
            cycle();
        end
        cmp_done  = 1'b0;
        cmp_error = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        src_data  = '0;
        cmp_done  = 1'b0;
        cmp_error = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset values, then a long quiet stretch must not trip the watchdog.
        cycles(2);
        rst_n = 1'b1;
        cycles(50);
        chk("idle_no_timeout", timeout, 1'b0);
        chk("idle_not_busy", busy, 1'b0);

        // All four sources valid: strict rotation 0,1,2,3 with one-cycle latency.
        for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 32'h1000 + i;
        src_valid = 4'hF;
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_valid", cmp_valid, 1'b1);
            chk("rr_src", cmp_src, k % N);
            chk("rr_data", cmp_data, 32'h1000 + (k % N));
        end
        chk("rr_beats", beat_count, 32'd8);

        // Move the pointer to 2, then only sources 1 and 3 request.
        src_valid = 4'b0010;
        cycle();
        chk("sparse_pre", cmp_src, 1);
        src_valid = 4'b1010;
        cycle();
        chk("sparse_a", cmp_src, 3);
        cycle();
        chk("sparse_b", cmp_src, 1);
        cycle();
        chk("sparse_c", cmp_src, 3);

        rand_run(200, 0, 0, 0);

        // Done after six beats gives a held PASS with no further grants.
        do_reset();
        src_valid = 4'hF;
        cycles(7);
        chk("pass_beats", beat_count, 32'd6);
        src_valid = 4'h0;
        cmp_done  = 1'b1;
        cycle();
        cmp_done = 1'b0;
        chk("pass_set", pass, 1'b1);
        chk("pass_busy", busy, 1'b0);
        src_valid = 4'hF;
        #1;
        chk("pass_ready", src_ready, 4'h0);
        cycles(5);
        chk("pass_held", pass, 1'b1);

        // Error and done together resolve to FAIL; the exit-cycle beat still goes out.
        do_reset();
        src_valid = 4'hF;
        cycles(4);
        cmp_error = 1'b1;
        cmp_done  = 1'b1;
        cycle();
        cmp_error = 1'b0;
        cmp_done  = 1'b0;
        chk("fail_set", fail, 1'b1);
        chk("fail_not_pass", pass, 1'b0);
        chk("fail_last_beat", cmp_valid, 1'b1);
        cycle();
        chk("fail_beat_gone", cmp_valid, 1'b0);

        // Watchdog: one beat then silence.
        do_reset();
        src_valid = 4'b0100;
        cycles(2);
        src_valid = 4'h0;
        cycles(15);
        chk("wd_not_yet", timeout, 1'b0);
        cycle();
        chk("wd_fire", timeout, 1'b1);

        // Watchdog restart: a beat on silent cycle 15 clears the count.
        do_reset();
        src_valid = 4'b0100;
        cycles(2);
        src_valid = 4'h0;
        cycles(14);
        src_valid = 4'b0100;
        cycle();
        src_valid = 4'h0;
        cycles(15);
        chk("wd_restart_none", timeout, 1'b0);
        chk("wd_restart_busy", busy, 1'b1);
        cycle();
        chk("wd_restart_fire", timeout, 1'b1);

        // Reset during continuous traffic, then arbitration resumes at source 0.
        do_reset();
        src_valid = 4'hF;
        cycles(6);
        rst_n = 1'b0;
        cycle();
        chk("midrst_valid", cmp_valid, 1'b0);
        chk("midrst_beats", beat_count, 32'd0);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycle();
        #1;
        chk("restart_ready", src_ready, 4'b0001);
        cycle();
        chk("restart_src", cmp_src, 0);

        // Long random mix of traffic, verdicts and resets.
        do_reset();
        rand_run(1500, 5, 3, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
